compressor_arbiter: RTL and testbench

- Packet-level round-robin arbiter sharing one Compressor instance between NUM_SRC AXI-stream packet sources.
- Grants one source per packet and holds the grant until that packet's tlast beat is accepted.
- Forwards beats through a one-entry registered slice into the Compressor's data_in/tvalid/tlast, and honours the Compressor's tready output as backpressure.
- Sits between the ingress packet FIFOs and the Compressor.

---
 rtl/compressor_pkg.sv | 14 +
 rtl/compressor_arbiter_rr_pick.sv | 27 ++
 rtl/compressor_arbiter.sv | 108 ++++++++++
 tb/tb_compressor_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_pkg.sv
// Shared constants and state encoding for the
// compressor ingress arbiter.
package compressor_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_DATA   = 8;
  localparam int BEAT_W     = DATA_WIDTH * NUM_DATA;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/compressor_arbiter_rr_pick.sv
// Combinational round-robin selector: first
// requester at or after ptr, wrapping.
module rr_pick
  import compressor_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);

  // Scan offsets high to low so the nearest one wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_SRC]) begin
        any = 1'b1;
        idx = SRC_W'((int'(ptr) + k) % NUM_SRC);
      end
    end
  end

endmodule

// File: rtl/compressor_arbiter.sv
// Packet round-robin arbiter sharing one Compressor
// between sources via a one-entry output slice.
module compressor_arbiter
  import compressor_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_SRC*BEAT_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [BEAT_W-1:0]         m_data,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [SRC_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      pkt_done
);

  state_t             r_state;
  logic [SRC_W-1:0]   r_ptr;
  logic [SRC_W-1:0]   r_grant;
  logic               r_busy;
  logic               r_pkt_done;
  logic               r_m_tvalid;
  logic               r_m_tlast;
  logic [BEAT_W-1:0]  r_m_data;

  logic               w_any;
  logic [SRC_W-1:0]   w_idx;
  logic               w_rdy;
  logic               w_acc;
  logic               w_last;
  logic [BEAT_W-1:0]  w_beat;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req (s_tvalid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Slice can take a beat when empty or draining.
  assign w_rdy  = (r_state == GRANT) &&
                  (!r_m_tvalid || m_tready);
  assign w_acc  = w_rdy && s_tvalid[r_grant];
  assign w_last = s_tlast[r_grant];
  assign w_beat = s_data[int'(r_grant)*BEAT_W +: BEAT_W];

  assign s_tready = w_rdy ? (NUM_SRC'(1) << r_grant)
                          : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_acc) begin
        r_m_data   <= w_beat;
        r_m_tlast  <= w_last;
        r_m_tvalid <= 1'b1;
      end else if (r_m_tvalid && m_tready) begin
        r_m_tvalid <= 1'b0;
      end
      unique case (r_state)
        IDLE: begin
          if (enable && w_any) begin
            r_grant <= w_idx;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_acc && w_last) begin
            r_pkt_done <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
            r_ptr      <= (r_grant == SRC_W'(NUM_SRC - 1))
                          ? '0 : r_grant + 1'b1;
          end
        end
      endcase
    end
  end

  assign m_data   = r_m_data;
  assign m_tvalid = r_m_tvalid;
  assign m_tlast  = r_m_tlast;
  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_compressor_arbiter.sv
// Directed bench for compressor_arbiter: source
// queues, output/grant monitor, hand-built expectations.
module tb_compressor_arbiter;
  import compressor_pkg::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [N*BEAT_W-1:0] s_data;
  logic [N-1:0]       s_tvalid;
  logic [N-1:0]       s_tlast;
  logic [N-1:0]       s_tready;
  logic [BEAT_W-1:0]  m_data;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tready;
  logic [1:0]         grant_id;
  logic               busy;
  logic               pkt_done;

  always #5 clk = ~clk;

  compressor_arbiter #(.NUM_SRC(N), .SRC_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .s_data   (s_data),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_data   (m_data),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  typedef struct packed {
    logic [BEAT_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t srcq [N][$];
  beat_t outq [$];
  int    grantq [$];
  int    pkt_cnt = 0;
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string tag,
                     input logic [BEAT_W-1:0] got,
                     input logic [BEAT_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] bt(int s, int p, int b);
    logic [31:0] w;
    w = {8'hA0, 8'(s), 8'(p), 8'(b)};
    return {8{w}};
  endfunction

  function automatic int gq(int i);
    return (i < grantq.size()) ? grantq[i] : -1;
  endfunction

  function automatic beat_t oq(int i);
    beat_t z;
    z = '0;
    return (i < outq.size()) ? outq[i] : z;
  endfunction

  task automatic push_beat(int s, logic [BEAT_W-1:0] d, logic l);
    beat_t x;
    x.d = d;
    x.l = l;
    srcq[s].push_back(x);
  endtask

  task automatic push_pkt(int s, int p, int nb);
    for (int b = 0; b < nb; b++)
      push_beat(s, bt(s, p, b), b == nb - 1);
  endtask

  // Source driver and output/grant monitor.
  initial begin
    logic [N-1:0] acc;
    logic         om;
    beat_t        ob;
    logic         prev_busy;
    s_tvalid  = '0;
    s_tlast   = '0;
    s_data    = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      acc  = s_tvalid & s_tready;
      om   = m_tvalid & m_tready;
      ob.d = m_data;
      ob.l = m_tlast;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i] && srcq[i].size() > 0)
          void'(srcq[i].pop_front());
      if (om) outq.push_back(ob);
      if (pkt_done) pkt_cnt++;
      if (busy && !prev_busy) grantq.push_back(int'(grant_id));
      prev_busy = busy;
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() > 0) begin
          s_tvalid[i] = 1'b1;
          s_tlast[i]  = srcq[i][0].l;
          s_data[i*BEAT_W +: BEAT_W] = srcq[i][0].d;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pkts(input string tag, input int n);
    int k;
    k = 0;
    while (pkt_cnt < n && k < 200) begin
      tick();
      k++;
    end
    chk(tag, pkt_cnt >= n, 1);
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!busy && k < 50) begin
      tick();
      k++;
    end
    chk(tag, busy, 1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    tick();
    tick();
    reset = 1'b0;
    outq.delete();
    grantq.delete();
  endtask

  initial begin
    logic [BEAT_W-1:0] b0;
    logic [BEAT_W-1:0] held;
    beat_t             exp_q [$];
    int                base;
    int                k;
    int                idle;
    int                started;
    int                bc;

    reset    = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    tick();
    tick();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_done", pkt_done, 0);

    // Single source, three beats, no backpressure.
    do_reset();
    base = pkt_cnt;
    b0 = bt(0, 0, 0);
    b0[111:96]  = 16'h0008;
    b0[191:184] = 8'h06;
    push_beat(0, b0, 1'b0);
    push_beat(0, bt(0, 0, 1), 1'b0);
    push_beat(0, bt(0, 0, 2), 1'b1);
    k = 0;
    while (!(s_tvalid[0] && s_tready[0]) && k < 50) begin
      tick();
      k++;
    end
    chk("t1_accept_seen", k < 50, 1);
    tick();
    chk("t1_latency_valid", m_tvalid, 1);
    chk("t1_b0_data", m_data, b0);
    chk("t1_b0_f16", m_data[111:96], 16'h0008);
    chk("t1_b0_f8", m_data[191:184], 8'h06);
    wait_pkts("t1_wait_done", base + 1);
    tick();
    tick();
    chk("t1_nbeats", outq.size(), 3);
    chk("t1_d0", oq(0).d, b0);
    chk("t1_d1", oq(1).d, bt(0, 0, 1));
    chk("t1_d2", oq(2).d, bt(0, 0, 2));
    chk("t1_lasts", {oq(0).l, oq(1).l, oq(2).l}, 3'b001);
    chk("t1_one_done", pkt_cnt, base + 1);
    chk("t1_grant_id", grant_id, 0);

    // Round robin between sources 0 and 2.
    do_reset();
    base = pkt_cnt;
    push_pkt(0, 0, 2);
    push_pkt(0, 1, 2);
    push_pkt(2, 0, 2);
    push_pkt(2, 1, 2);
    idle = 0;
    started = 0;
    k = 0;
    while (pkt_cnt < base + 4 && k < 200) begin
      tick();
      k++;
      if (busy) started = 1;
      else if (started != 0 && pkt_cnt < base + 4) idle++;
    end
    chk("t2_wait_done", pkt_cnt >= base + 4, 1);
    tick();
    tick();
    chk("t2_g0", gq(0), 0);
    chk("t2_g1", gq(1), 2);
    chk("t2_g2", gq(2), 0);
    chk("t2_g3", gq(3), 2);
    chk("t2_idle_cycles", idle, 3);
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s <= 2; s += 2)
        for (int b = 0; b < 2; b++) begin
          beat_t x;
          x.d = bt(s, p, b);
          x.l = (b == 1);
          exp_q.push_back(x);
        end
    chk("t2_nbeats", outq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_beat%0d", i), oq(i), exp_q[i]);

    // Backpressure on a four-beat packet.
    do_reset();
    base = pkt_cnt;
    for (int b = 0; b < 4; b++)
      push_beat(1, {8{32'hFEDC_BA98}} ^ BEAT_W'(b), b == 3);
    k = 0;
    while (!m_tvalid && k < 50) begin
      tick();
      k++;
    end
    chk("t3_first_valid", m_tvalid, 1);
    m_tready = 1'b0;
    #1;
    chk("t3_stall_rdy0", s_tready, 0);
    held = m_data;
    tick();
    chk("t3_stall_data1", m_data, held);
    chk("t3_stall_valid1", m_tvalid, 1);
    chk("t3_stall_rdy1", s_tready, 0);
    tick();
    chk("t3_stall_data2", m_data, held);
    chk("t3_stall_rdy2", s_tready, 0);
    m_tready = 1'b1;
    wait_pkts("t3_wait_done", base + 1);
    tick();
    tick();
    chk("t3_nbeats", outq.size(), 4);
    for (int b = 0; b < 4; b++)
      chk($sformatf("t3_beat%0d", b), oq(b).d,
          {8{32'hFEDC_BA98}} ^ BEAT_W'(b));
    chk("t3_last", oq(3).l, 1);

    // Enable gating.
    do_reset();
    base = pkt_cnt;
    enable = 1'b0;
    for (int s = 0; s < N; s++) push_pkt(s, 0, 3);
    tick();
    tick();
    tick();
    chk("t4_off_busy", busy, 0);
    chk("t4_off_rdy", s_tready, 0);
    enable = 1'b1;
    wait_busy("t4_grant");
    chk("t4_first_grant", grant_id, 0);
    tick();
    enable = 1'b0;
    wait_pkts("t4_wait_done", base + 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_hold_busy", busy, 0);
    chk("t4_hold_rdy", s_tready, 0);
    chk("t4_hold_count", pkt_cnt, base + 1);
    enable = 1'b1;
    wait_pkts("t4_wait_rest", base + 4);
    chk("t4_g1", gq(1), 1);
    chk("t4_g2", gq(2), 2);
    chk("t4_g3", gq(3), 3);

    // Reset in the middle of a packet.
    do_reset();
    base = pkt_cnt;
    push_pkt(2, 0, 4);
    k = 0;
    while (!m_tvalid && k < 50) begin
      tick();
      k++;
    end
    chk("t5_started", grant_id, 2);
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", m_tvalid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant", grant_id, 0);
    srcq[2].delete();
    tick();
    push_pkt(3, 0, 2);
    reset = 1'b0;
    outq.delete();
    grantq.delete();
    tick();
    chk("t5_idle_cycle", busy, 0);
    wait_busy("t5_regrant");
    chk("t5_grant3", grant_id, 3);
    wait_pkts("t5_wait_done", base + 1);
    tick();
    tick();
    chk("t5_nbeats", outq.size(), 2);
    chk("t5_d0", oq(0).d, bt(3, 0, 0));
    chk("t5_d1", oq(1).d, bt(3, 0, 1));

    // Pointer wrap with single-beat packets.
    base = pkt_cnt;
    push_pkt(2, 5, 1);
    wait_pkts("t6_src2_done", base + 1);
    tick();
    tick();
    grantq.delete();
    outq.delete();
    base = pkt_cnt;
    push_pkt(0, 6, 1);
    push_pkt(3, 6, 1);
    bc = 0;
    k = 0;
    while (pkt_cnt < base + 2 && k < 100) begin
      tick();
      k++;
      if (busy) bc++;
    end
    chk("t6_wait_done", pkt_cnt >= base + 2, 1);
    tick();
    tick();
    chk("t6_g0", gq(0), 3);
    chk("t6_g1", gq(1), 0);
    chk("t6_busy_cycles", bc, 2);
    chk("t6_done_count", pkt_cnt, base + 2);
    chk("t6_out0", oq(0), {bt(3, 6, 0), 1'b1});
    chk("t6_out1", oq(1), {bt(0, 6, 0), 1'b1});

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
